// File: rtl/beatmap_pkg.sv
// Shared constants and types for the beatmap note receiver.
// Note codes are NOTE_BASE + NOTE_STEP * lane for lane 0..NUM_LANES-1.
// Any other code is treated as invalid.
package beatmap_pkg;

    localparam logic [7:0] NOTE_BASE = 8'd20;
    localparam logic [7:0] NOTE_STEP = 8'd4;
    localparam logic [7:0] NOTE_MAX  = 8'd36;
    localparam int         NUM_LANES = 5;
    localparam int         LANE_W    = 3;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Returns 1 when code is a legal note code. NOTE_BASE is a multiple of
    // NOTE_STEP, so checking the two LSBs of the raw code gives the
    // alignment check directly.
    function automatic logic note_code_valid(input logic [7:0] code);
        return (code >= NOTE_BASE) && (code <= NOTE_MAX) && (code[1:0] == 2'b00);
    endfunction

    // Converts a note code to its lane index. The result is only
    // meaningful when note_code_valid(code) is 1.
    function automatic logic [LANE_W-1:0] note_code_lane(input logic [7:0] code);
        return LANE_W'((code - NOTE_BASE) >> 2);
    endfunction

endpackage

// File: rtl/note_fifo.sv
// Synchronous FIFO that holds lane indices.
// Ports:
//   clk, resetn : clock and synchronous active-low reset
//   push/wr_data: write request and data. A push into a full FIFO is
//                 accepted only when a pop happens in the same cycle.
//   pop         : read request. It is ignored when the FIFO is empty.
//   rd_data     : head entry. It reads as 0 while the FIFO is empty.
//   level/full/empty : occupancy status
// DEPTH must be a power of two and at least 2. The pointers wrap
// naturally at their bit width.
module note_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             push_s;
    logic             pop_s;

    assign empty  = (level_r == LW'(0));
    assign full   = (level_r == LW'(DEPTH));
    assign level  = level_r;
    assign pop_s  = pop && !empty;
    // While the FIFO is full, the slot being vacated by the pop is the
    // slot that gets written. The new entry therefore lands at the tail.
    assign push_s = push && (!full || pop_s);
    assign rd_data = empty ? WIDTH'(0) : mem_r[rd_ptr_r];

    // Storage array write. This array is not reset because reads are
    // gated by empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy update.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= LW'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/beatmap_note_receiver.sv
// Beatmap note receiver. It validates incoming note codes and tracks
// synchronisation to the stream: the first note after reset, or after an
// invalid code, must be lane 0 (code 20). Accepted lanes are queued for
// the game logic.
// Ports:
//   clk, resetn     : clock and synchronous active-low reset
//   data_en, data   : incoming note code strobe and value
//   q_ready         : consumer accepts the head note
//   q_valid, q_lane : head of the note queue
//   level, full     : queue occupancy
//   overflow        : sticky flag, set when a note was dropped on a full queue
//   synced          : the receiver is locked to the stream (RUN state)
//   err_cnt         : saturating count of invalid codes
module beatmap_note_receiver
    import beatmap_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int ERR_W = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   data_en,
    input  logic [7:0]             data,
    input  logic                   q_ready,
    output logic                   q_valid,
    output logic [2:0]             q_lane,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   overflow,
    output logic                   synced,
    output logic [ERR_W-1:0]       err_cnt
);

    state_t             state_r;
    state_t             state_nxt_s;
    logic               push_s;
    logic               err_inc_s;
    logic               code_ok_s;
    logic [2:0]         lane_s;
    logic               empty_s;
    logic               overflow_r;
    logic [ERR_W-1:0]   err_cnt_r;

    assign code_ok_s = note_code_valid(data);
    assign lane_s    = note_code_lane(data);

    note_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (3)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (push_s),
        .pop     (q_ready),
        .wr_data (lane_s),
        .rd_data (q_lane),
        .level   (level),
        .full    (full),
        .empty   (empty_s)
    );

    assign q_valid  = !empty_s;
    assign synced   = (state_r == RUN);
    assign overflow = overflow_r;
    assign err_cnt  = err_cnt_r;

    // Next-state logic plus push and error-count decisions for the sampled code.
    always_comb begin
        state_nxt_s = state_r;
        push_s      = 1'b0;
        err_inc_s   = 1'b0;
        if (data_en) begin
            if (!code_ok_s) begin
                state_nxt_s = SYNC;
                err_inc_s   = 1'b1;
            end else begin
                case (state_r)
                    SYNC: begin
                        if (lane_s == 3'd0) begin
                            push_s      = 1'b1;
                            state_nxt_s = RUN;
                        end else begin
                            state_nxt_s = SYNC;
                        end
                    end
                    RUN: begin
                        push_s      = 1'b1;
                        state_nxt_s = RUN;
                    end
                    default: begin
                        state_nxt_s = SYNC;
                    end
                endcase
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State register, sticky overflow flag and saturating error counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= SYNC;
            overflow_r <= 1'b0;
            err_cnt_r  <= ERR_W'(0);
        end else begin
            state_r <= state_nxt_s;
            // A push is dropped only when the queue is full and no pop
            // frees a slot in the same cycle.
            if (push_s && full && !(q_ready && q_valid)) begin
                overflow_r <= 1'b1;
            end
            if (err_inc_s && (err_cnt_r != {ERR_W{1'b1}})) begin
                err_cnt_r <= err_cnt_r + ERR_W'(1);
            end
        end
    end

endmodule
